// File: rtl/imem_loader_if.sv
// Loader-side bundle: UART byte stream in, instruction-memory write port and
// load status out. master = loader, slave = the UART/memory/CPU side.
interface imem_loader_if #(
  parameter int unsigned ADDR_W = 14
);
  logic              start;
  logic              rx_valid;
  logic [7:0]        rx_byte;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              cpu_hold;
  logic              done;
  logic              err;
  logic [ADDR_W:0]   word_count;

  modport master (
    input  start, rx_valid, rx_byte,
    output wr_en, wr_addr, wr_data, cpu_hold, done, err, word_count
  );

  modport slave (
    output start, rx_valid, rx_byte,
    input  wr_en, wr_addr, wr_data, cpu_hold, done, err, word_count
  );
endinterface

// File: rtl/imem_loader.sv
// Length-prefixed byte-stream loader: packs big-endian bytes into 32-bit words
// and writes them to consecutive instruction-memory addresses, holding the CPU.
module imem_loader #(
  parameter int unsigned ADDR_W  = 14,
  parameter int unsigned TIMEOUT = 1000000
) (
  input  logic          clock,
  input  logic          reset,
  imem_loader_if.master bus
);

  localparam int unsigned TMO_W     = $clog2(TIMEOUT + 1);
  localparam logic [32:0] MAX_WORDS = 33'(1) << ADDR_W;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_DATA,
    ST_DONE,
    ST_ERR
  } state_t;

  state_t            state_q,   state_d;
  logic [15:0]       len_q,     len_d;
  logic [23:0]       word_q,    word_d;
  logic [1:0]        idx_q,     idx_d;
  logic [TMO_W-1:0]  tmo_q,     tmo_d;
  logic [ADDR_W:0]   wc_q,      wc_d;
  logic              wr_en_q,   wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]       wr_data_q, wr_data_d;

  logic [15:0]       len_full;
  logic [ADDR_W:0]   wc_inc;
  logic              last_wr;
  logic              tmo_hit;

  assign len_full = {len_q[15:8], bus.rx_byte};
  assign wc_inc   = wc_q + (ADDR_W+1)'(1);
  assign last_wr  = (32'(wc_inc) == 32'(len_q));
  assign tmo_hit  = (tmo_q == TMO_W'(TIMEOUT - 1));

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    word_d    = word_q;
    idx_d     = idx_q;
    tmo_d     = tmo_q;
    wc_d      = wc_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (bus.start) begin
          state_d = ST_LEN_HI;
          wc_d    = '0;
          idx_d   = '0;
          tmo_d   = '0;
        end
      end

      ST_LEN_HI: begin
        if (bus.rx_valid) begin
          len_d[15:8] = bus.rx_byte;
          tmo_d       = '0;
          state_d     = ST_LEN_LO;
        end else if (tmo_hit) begin
          state_d = ST_ERR;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end

      ST_LEN_LO: begin
        if (bus.rx_valid) begin
          len_d[7:0] = bus.rx_byte;
          tmo_d      = '0;
          if (len_full == 16'd0)
            state_d = ST_DONE;
          else if (33'(len_full) > MAX_WORDS)
            state_d = ST_ERR;
          else
            state_d = ST_DATA;
        end else if (tmo_hit) begin
          state_d = ST_ERR;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end

      ST_DATA: begin
        // The count bumps during the wr_en cycle; a byte arriving alongside a
        // non-final write is the next word's first byte and is still accepted.
        if (wr_en_q)
          wc_d = wc_inc;
        if (wr_en_q && last_wr) begin
          state_d = ST_DONE;
        end else if (bus.rx_valid) begin
          tmo_d  = '0;
          idx_d  = idx_q + 2'd1;
          word_d = {word_q[15:0], bus.rx_byte};
          if (idx_q == 2'd3) begin
            wr_en_d   = 1'b1;
            wr_addr_d = wc_q[ADDR_W-1:0];
            wr_data_d = {word_q, bus.rx_byte};
          end
        end else if (tmo_hit) begin
          state_d = ST_ERR;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      len_q     <= '0;
      word_q    <= '0;
      idx_q     <= '0;
      tmo_q     <= '0;
      wc_q      <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      word_q    <= word_d;
      idx_q     <= idx_d;
      tmo_q     <= tmo_d;
      wc_q      <= wc_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign bus.wr_en      = wr_en_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.word_count = wc_q;
  assign bus.cpu_hold   = (state_q == ST_LEN_HI) || (state_q == ST_LEN_LO) ||
                          (state_q == ST_DATA);
  assign bus.done       = (state_q == ST_DONE);
  assign bus.err        = (state_q == ST_ERR);

endmodule

// File: doc/imem_loader.md
# imem_loader

Byte-stream program loader that writes instruction words into the instruction memory write port, sitting between the UART receiver and the memory that the fetch unit reads from. It parses a length-prefixed image, packs bytes into 32-bit words, issues one write per word at consecutive word addresses, and holds the CPU in reset for the duration of a load.

## Interface

- ADDR_W, 14: instruction memory word-address width. Memory capacity is 2^ADDR_W words.
- TIMEOUT, 1000000: maximum idle clocks allowed between bytes once a load has begun.

- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  reset, asynchronous, active-high.
- start  in  1  single-cycle pulse; begins a load.
- rx_valid  in  1  single-cycle strobe; rx_byte is valid this cycle.
- rx_byte  in  8  received byte.
- wr_en  out  1  instruction memory write strobe, one cycle per word.
- wr_addr  out  ADDR_W  word address of the write.
- wr_data  out  32  instruction word.
- cpu_hold  out  1  high while loading; ORed into the CPU reset.
- done  out  1  level; the last load completed successfully.
- err  out  1  level; the last load aborted.
- word_count  out  ADDR_W+1  words written in the current or last load.

## Operation

- States: IDLE, LEN_HI, LEN_LO, DATA, DONE, ERR.
- Image format: 16-bit word count N, sent high byte first, then N words of 4 bytes each, most significant byte first.
- IDLE/DONE/ERR + start -> LEN_HI. On entry: clear word_count, byte index, done and err. Raise cpu_hold.
- start in LEN_HI, LEN_LO or DATA is ignored.
- LEN_HI + rx_valid -> latch N[15:8], go to LEN_LO.
- LEN_LO + rx_valid -> latch N[7:0], then:
  - N == 0 -> DONE.
  - N > 2^ADDR_W -> ERR.
  - otherwise -> DATA.
- DATA + rx_valid: shift the byte into the word assembly register and increment the 2-bit byte index.
- On the 4th byte of a word, the next cycle drives:
  - wr_en = 1
  - wr_addr = word_count[ADDR_W-1:0]
  - wr_data = the assembled word
  - word_count increments by 1 in that same cycle.
- When word_count reaches N after a write -> DONE.
- rx_valid in IDLE, DONE or ERR is discarded. No writes occur in these states.
- Timeout counter:
  - Clears on every accepted byte and on start.
  - Counts in LEN_HI, LEN_LO and DATA.
  - Reaching TIMEOUT -> ERR. A partial word is dropped and not written.
- DONE: done = 1, cpu_hold = 0. ERR: err = 1, cpu_hold = 0. In both, word_count holds its final value.
- Addresses never wrap, because N ≤ 2^ADDR_W is checked before DATA.

## Timing

- Reset values:
  - state = IDLE
  - wr_en = 0, wr_addr = 0, wr_data = 0
  - cpu_hold = 0, done = 0, err = 0, word_count = 0
- Reset mid-load returns to IDLE immediately. Any pending write is cancelled.
- cpu_hold rises the cycle after start is sampled. It falls the cycle the FSM enters DONE or ERR.
- Write latency is exactly 1 clock after the 4th byte's rx_valid cycle. wr_en is never high for 2 consecutive cycles.
- Byte strobes may arrive on back-to-back clocks. Every strobe is accepted and no byte is dropped.
- Last word: its wr_en cycle and the DONE transition coincide. done is visible the next cycle.
- start coinciding with rx_valid in IDLE: start wins and the byte is discarded.

## Test plan

- Normal load: start, then bytes 00 02 | 12 34 56 78 | 9A BC DE F0 -> writes addr 0 = 0x12345678 and addr 1 = 0x9ABCDEF0. Then done = 1, word_count = 2, cpu_hold = 0.
- Zero length: start, then 00 00 -> DONE with no wr_en pulse and word_count = 0.
- Oversize: with ADDR_W = 14, start then 40 01 -> ERR with err = 1 and no writes.
- Timeout: with TIMEOUT = 16, start, 00 01, AA BB, then silence for 16 clocks -> ERR with no write and cpu_hold = 0.
- Reset mid-DATA after 5 bytes -> all outputs return to reset values. A new start followed by a full 1-word image writes addr 0 correctly.
- Back-to-back rx_valid every clock for a 3-word image -> 3 single-cycle wr_en pulses at addrs 0, 1, 2. A start issued mid-load has no effect.
